// File: rtl/tilexy_cl_rcv_drain_pkg.sv
// Shared cache-line receive types: line geometry, buffered entry layout,
// drain FSM states and a beat-select helper.
package tile_cl_pkg;

  localparam int CL_BEATS  = 8;
  localparam int CL_BEAT_W = 66;
  localparam int CL_ADDR_W = 37;
  localparam int CL_PHY_W  = 40;
  localparam int CL_DATA_W = CL_BEATS * CL_BEAT_W;
  localparam int CL_SIZE_W = CL_PHY_W + 2;
  localparam int CL_BIDX_W = $clog2(CL_BEATS);

  localparam logic [CL_BIDX_W-1:0] CL_LAST_BEAT = CL_BIDX_W'(CL_BEATS - 1);

  // One buffered delivery; expunges carry no meaningful data.
  typedef struct packed {
    logic [CL_DATA_W-1:0] data;
    logic [CL_ADDR_W-1:0] addr;
    logic                 shared;
    logic                 excl;
    logic [CL_PHY_W-1:0]  phy;
    logic                 expun;
  } cl_entry_t;

  // NEXT is a pass-through decision point evaluated in the pop cycle itself.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    INV  = 2'd2,
    NEXT = 2'd3
  } rcv_state_t;

  // Beat k of a line lives at [66k+65:66k].
  function automatic logic [CL_BEAT_W-1:0] cl_beat_sel(
    input logic [CL_DATA_W-1:0] line,
    input logic [CL_BIDX_W-1:0] k
  );
    return line[int'(k) * CL_BEAT_W +: CL_BEAT_W];
  endfunction

endpackage

// File: rtl/tilexy_cl_rcv_drain_line_ram.sv
// cl_line_ram: DEPTH-entry line store, one write port and one
// combinational read port. Contents are not reset; the pointers in the
// parent decide what is valid.
module cl_line_ram
  import tile_cl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  cl_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output cl_entry_t                rdata
);

  cl_entry_t mem [DEPTH];

  // Write port: one delivery per cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tilexy_cl_rcv_drain.sv
// tilexy_cl_rcv_drain: buffers cache lines delivered by the tile fifo and
// drains each one to the L2 fill port as 8 x 66b beats (valid/ready), or as
// a single invalidate for expunges. The producer cannot be stalled, so the
// block exports almost_full and a sticky overflow flag.
//
// Optional feature, macro CL_RCV_BYPASS_EN: a data line arriving into an
// idle, empty block loads straight into the head register without using a
// buffer slot; almost_full then treats the head register as one extra slot.
module tilexy_cl_rcv_drain
  import tile_cl_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_en,
  input  logic [CL_DATA_W-1:0]      in_data,
  input  logic [3:0][CL_ADDR_W-1:0] in_addr,
  input  logic [CL_SIZE_W-1:0]      in_size,
  input  logic                      in_expun,
  output logic                      almost_full,
  output logic                      overflow,
  output logic                      fill_valid,
  input  logic                      fill_ready,
  output logic [CL_ADDR_W-1:0]      fill_addr,
  output logic [CL_BIDX_W-1:0]      fill_beat,
  output logic [CL_BEAT_W-1:0]      fill_data,
  output logic                      fill_first,
  output logic                      fill_last,
  output logic                      fill_shared,
  output logic                      fill_excl,
  output logic [CL_PHY_W-1:0]       fill_phy,
  output logic                      inv_valid,
  input  logic                      inv_ready,
  output logic [CL_ADDR_W-1:0]      inv_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
`ifdef CL_RCV_BYPASS_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif

  rcv_state_t state, state_nxt, st_eval;
  logic [CL_BIDX_W-1:0] beat, beat_nxt;
  logic [AW:0]   wptr, rptr, rptr_inc, count;
  logic [AW+1:0] occ;
  logic [AW-1:0] rd_addr;
  logic          full, empty;
  logic          push_ok, pop_done, ram_pop, ram_avail, byp_load;
  logic          head_ld, head_byp, head_byp_nxt;
  cl_entry_t     in_entry, rd_entry, head_p0, head_p1;
  logic          unused_ok;

  // Only the first address replica is meaningful; the head's expunge bit is
  // consumed before it is registered.
  assign unused_ok = ^{in_addr[3:1], head_p1.expun};

  // Pack the delivery into the buffered entry layout.
  always_comb begin
    in_entry        = '0;
    in_entry.data   = in_data;
    in_entry.addr   = in_addr[0];
    in_entry.shared = in_size[CL_PHY_W+1];
    in_entry.excl   = in_size[CL_PHY_W];
    in_entry.phy    = in_size[CL_PHY_W-1:0];
    in_entry.expun  = in_expun;
  end

  // Pointers carry one wrap bit; full/empty come from the MSB compare.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count    = wptr - rptr;
  assign rptr_inc = rptr + PTR_ONE;

  // A line is released only on its beat-7 handshake, an expunge on inv_ready.
  assign pop_done = ((state == FILL) && fill_ready && (beat == CL_LAST_BEAT)) ||
                    ((state == INV) && inv_ready);

`ifdef CL_RCV_BYPASS_EN
  assign byp_load = (state == IDLE) && empty && in_en && !in_expun;
  assign ram_pop  = pop_done && !head_byp;
  assign occ      = {1'b0, count} + {{(AW+1){1'b0}}, head_byp};
`else
  assign byp_load = 1'b0;
  assign ram_pop  = pop_done;
  assign occ      = {1'b0, count};
`endif

  // A full buffer still accepts when its head frees in the same cycle.
  assign push_ok   = in_en && !byp_load && (!full || ram_pop);
  // While popping, the successor is one past the head.
  assign ram_avail = ram_pop ? (count != PTR_ONE) : !empty;
  assign rd_addr   = ram_pop ? rptr_inc[AW-1:0] : rptr[AW-1:0];

  assign almost_full = (int'(occ) + AF_LEVEL) >= CAP;

  cl_line_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (in_entry),
    .raddr (rd_addr),
    .rdata (rd_entry)
  );

  // Drain FSM: pick the next head in IDLE or in the pop cycle (NEXT) so
  // consecutive lines leave with no bubble.
  always_comb begin
    st_eval      = pop_done ? NEXT : state;
    state_nxt    = state;
    beat_nxt     = beat;
    head_ld      = 1'b0;
    head_p0      = rd_entry;
    head_byp_nxt = head_byp;
    if ((state == FILL) && fill_ready) begin
      beat_nxt = beat + 1'b1;
    end
    case (st_eval)
      IDLE, NEXT: begin
        head_byp_nxt = 1'b0;
        beat_nxt     = '0;
        if (byp_load) begin
          head_p0      = in_entry;
          head_ld      = 1'b1;
          head_byp_nxt = 1'b1;
          state_nxt    = FILL;
        end else if (ram_avail) begin
          head_p0   = rd_entry;
          head_ld   = 1'b1;
          state_nxt = rd_entry.expun ? INV : FILL;
        end else if (push_ok) begin
          // Empty buffer: the entry being written now is also the new head.
          head_p0   = in_entry;
          head_ld   = 1'b1;
          state_nxt = in_expun ? INV : FILL;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: ;
    endcase
  end

  // Control state; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      head_byp <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      head_byp <= head_byp_nxt;
      if (push_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (ram_pop) begin
        rptr <= rptr_inc;
      end
      if (in_en && !push_ok && !byp_load) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head register: holds the line being drained; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (head_ld) begin
      head_p1 <= head_p0;
    end
  end

  assign fill_valid  = (state == FILL);
  assign fill_beat   = fill_valid ? beat : '0;
  assign fill_data   = fill_valid ? cl_beat_sel(head_p1.data, beat) : '0;
  assign fill_addr   = fill_valid ? head_p1.addr : '0;
  assign fill_first  = fill_valid && (beat == '0);
  assign fill_last   = fill_valid && (beat == CL_LAST_BEAT);
  assign fill_shared = fill_valid && head_p1.shared;
  assign fill_excl   = fill_valid && head_p1.excl;
  assign fill_phy    = fill_valid ? head_p1.phy : '0;
  assign inv_valid   = (state == INV);
  assign inv_addr    = inv_valid ? head_p1.addr : '0;

endmodule

// File: tb/tb_tilexy_cl_rcv_drain.sv
// Directed bench for tilexy_cl_rcv_drain (default build, DEPTH=4, AF_LEVEL=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tilexy_cl_rcv_drain;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_en;
  logic [527:0]      in_data;
  logic [3:0][36:0]  in_addr;
  logic [41:0]       in_size;
  logic              in_expun;
  logic              almost_full, overflow;
  logic              fill_valid, fill_ready;
  logic [36:0]       fill_addr;
  logic [2:0]        fill_beat;
  logic [65:0]       fill_data;
  logic              fill_first, fill_last, fill_shared, fill_excl;
  logic [39:0]       fill_phy;
  logic              inv_valid, inv_ready;
  logic [36:0]       inv_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tilexy_cl_rcv_drain #(.DEPTH(4), .AF_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data), .in_addr(in_addr),
    .in_size(in_size), .in_expun(in_expun), .almost_full(almost_full),
    .overflow(overflow), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_addr(fill_addr), .fill_beat(fill_beat), .fill_data(fill_data),
    .fill_first(fill_first), .fill_last(fill_last), .fill_shared(fill_shared),
    .fill_excl(fill_excl), .fill_phy(fill_phy), .inv_valid(inv_valid),
    .inv_ready(inv_ready), .inv_addr(inv_addr)
  );

  // Beat k of line 'tag' carries tag*0x100 + k*0x11.
  function automatic logic [65:0] beat_val(input int tag, input int k);
    return 66'(tag * 256 + k * 17);
  endfunction

  function automatic logic [527:0] line_val(input int tag);
    logic [527:0] d;
    for (int k = 0; k < 8; k++) d[k*66 +: 66] = beat_val(tag, k);
    return d;
  endfunction

  task automatic drive_line(input int tag, input logic [36:0] addr, input logic expun);
    logic t0;
    t0 = tag[0];
    in_en      = 1'b1;
    in_data    = expun ? '0 : line_val(tag);
    in_addr[0] = addr;
    in_addr[1] = ~addr;
    in_addr[2] = ~addr;
    in_addr[3] = ~addr;
    in_size    = {t0, ~t0, 40'(addr) << 6};
    in_expun   = expun;
  endtask

  task automatic idle_in();
    in_en    = 1'b0;
    in_expun = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_in();
    fill_ready = 1'b0;
    inv_ready  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (fill_valid !== 1'b0 || inv_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got fill=%b inv=%b exp 0 0", fill_valid, inv_valid);
    end
    checks++;
    if (almost_full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got af=%b ov=%b exp 0 0", almost_full, overflow);
    end
    checks++;
    if (fill_data !== '0 || fill_addr !== '0 || fill_beat !== '0 || inv_addr !== '0) begin
      errors++;
      $display("FAIL reset_fields got data=%h addr=%h beat=%0d inv=%h exp 0", fill_data, fill_addr, fill_beat, inv_addr);
    end
  endtask

  task automatic test_single_line();
    do_reset();
    fill_ready = 1'b1;
    @(negedge clk);
    drive_line(0, 37'h1234, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle_in();
      checks++;
      if (fill_valid !== 1'b1 || fill_beat !== 3'(c) || fill_data !== beat_val(0, c) || fill_addr !== 37'h1234) begin
        errors++;
        $display("FAIL single_beat c=%0d got v=%b beat=%0d data=%h addr=%h exp v=1 beat=%0d data=%h addr=1234",
                 c, fill_valid, fill_beat, fill_data, fill_addr, c, beat_val(0, c));
      end
      checks++;
      if (fill_first !== (c == 0) || fill_last !== (c == 7)) begin
        errors++;
        $display("FAIL single_first_last c=%0d got first=%b last=%b exp %b %b", c, fill_first, fill_last, c == 0, c == 7);
      end
      if (c == 0) begin
        checks++;
        if (fill_shared !== 1'b0 || fill_excl !== 1'b1 || fill_phy !== (40'h1234 << 6)) begin
          errors++;
          $display("FAIL single_size got sh=%b ex=%b phy=%h exp 0 1 %h", fill_shared, fill_excl, fill_phy, 40'h1234 << 6);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end got fill_valid=%b exp 0", fill_valid);
    end
  endtask

  task automatic test_stall();
    int acc;
    do_reset();
    @(negedge clk);
    drive_line(5, 37'h0abc, 1'b0);
    @(negedge clk);
    idle_in();
    acc = 0;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      fill_ready = (c % 3 == 0);
      checks++;
      if (fill_valid !== 1'b1 || fill_beat !== 3'(acc) || fill_data !== beat_val(5, acc)) begin
        errors++;
        $display("FAIL stall_hold c=%0d got v=%b beat=%0d data=%h exp v=1 beat=%0d data=%h",
                 c, fill_valid, fill_beat, fill_data, acc, beat_val(5, acc));
      end
      if (fill_ready) acc++;
      @(negedge clk);
    end
    fill_ready = 1'b0;
    checks++;
    if (acc != 8 || fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_count got beats=%0d valid_after=%b exp 8 0", acc, fill_valid);
    end
  endtask

  task automatic test_mixed();
    logic       ev_fill, ev_inv;
    logic [2:0] ev_beat;
    logic [36:0] ev_addr;
    do_reset();
    fill_ready = 1'b1;
    inv_ready  = 1'b1;
    @(negedge clk);
    drive_line(1, 37'h100, 1'b0);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      if (cyc == 1) drive_line(0, 37'h55, 1'b1);
      else if (cyc == 2) drive_line(3, 37'h300, 1'b0);
      else idle_in();
      ev_fill = (cyc <= 8) || (cyc >= 10 && cyc <= 17);
      ev_inv  = (cyc == 9);
      ev_beat = (cyc <= 8) ? 3'(cyc - 1) : 3'(cyc - 10);
      ev_addr = (cyc <= 8) ? 37'h100 : (cyc == 9 ? 37'h55 : 37'h300);
      checks++;
      if (fill_valid !== ev_fill || inv_valid !== ev_inv) begin
        errors++;
        $display("FAIL mixed_valid cyc=%0d got fill=%b inv=%b exp %b %b", cyc, fill_valid, inv_valid, ev_fill, ev_inv);
      end
      if (ev_fill) begin
        checks++;
        if (fill_beat !== ev_beat || fill_addr !== ev_addr) begin
          errors++;
          $display("FAIL mixed_fill cyc=%0d got beat=%0d addr=%h exp %0d %h", cyc, fill_beat, fill_addr, ev_beat, ev_addr);
        end
      end
      if (ev_inv) begin
        checks++;
        if (inv_addr !== ev_addr) begin
          errors++;
          $display("FAIL mixed_inv got inv_addr=%h exp %h", inv_addr, ev_addr);
        end
      end
    end
  endtask

  task automatic test_full_overflow();
    int lines;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive_line(k, 37'(k * 16), 1'b0);
      @(negedge clk);
      idle_in();
      checks++;
      if (almost_full !== (k >= 3) || overflow !== (k >= 5)) begin
        errors++;
        $display("FAIL full_flags push=%0d got af=%b ov=%b exp %b %b", k, almost_full, overflow, k >= 3, k >= 5);
      end
    end
    fill_ready = 1'b1;
    lines = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (fill_valid === 1'b1 && fill_last === 1'b1) begin
        checks++;
        if (fill_addr !== 37'((lines + 1) * 16)) begin
          errors++;
          $display("FAIL full_order line=%0d got addr=%h exp %h", lines, fill_addr, 37'((lines + 1) * 16));
        end
        lines++;
      end
    end
    checks++;
    if (lines != 4 || overflow !== 1'b1 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got lines=%0d ov=%b af=%b exp 4 1 0", lines, overflow, almost_full);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic        found;
    int          lines;
    logic [36:0] last_addr;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive_line(k, 37'(k * 16), 1'b0);
    end
    @(negedge clk);
    idle_in();
    checks++;
    if (almost_full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL pp_full got af=%b ov=%b exp 1 0", almost_full, overflow);
    end
    fill_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (fill_valid === 1'b1 && fill_beat === 3'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL pp_beat7 got found=%b exp 1", found);
    end
    drive_line(5, 37'h50, 1'b0);
    @(negedge clk);
    idle_in();
    checks++;
    if (overflow !== 1'b0 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL pp_accept got ov=%b af=%b exp 0 1", overflow, almost_full);
    end
    checks++;
    if (fill_valid !== 1'b1 || fill_beat !== 3'd0 || fill_addr !== 37'h20) begin
      errors++;
      $display("FAIL pp_next got v=%b beat=%0d addr=%h exp 1 0 20", fill_valid, fill_beat, fill_addr);
    end
    lines = 0;
    last_addr = '0;
    for (int c = 0; c < 60; c++) begin
      if (fill_valid === 1'b1 && fill_last === 1'b1) begin
        lines++;
        last_addr = fill_addr;
      end
      @(negedge clk);
    end
    checks++;
    if (lines != 4 || last_addr !== 37'h50) begin
      errors++;
      $display("FAIL pp_drain got lines=%0d last=%h exp 4 50", lines, last_addr);
    end
  endtask

  task automatic test_reset_mid_line();
    logic found;
    int   beats;
    do_reset();
    fill_ready = 1'b1;
    @(negedge clk);
    drive_line(7, 37'h777, 1'b0);
    @(negedge clk);
    idle_in();
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (fill_valid === 1'b1 && fill_beat === 3'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_beat3 got found=%b exp 1", found);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (fill_valid !== 1'b0 || almost_full !== 1'b0 || inv_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort got v=%b af=%b inv=%b exp 0 0 0", fill_valid, almost_full, inv_valid);
    end
    @(negedge clk);
    checks++;
    if (fill_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet got v=%b exp 0", fill_valid);
    end
    drive_line(8, 37'h888, 1'b0);
    @(negedge clk);
    idle_in();
    checks++;
    if (fill_valid !== 1'b1 || fill_beat !== 3'd0 || fill_first !== 1'b1 ||
        fill_data !== beat_val(8, 0) || fill_addr !== 37'h888) begin
      errors++;
      $display("FAIL rstmid_restart got v=%b beat=%0d first=%b data=%h addr=%h exp 1 0 1 %h 888",
               fill_valid, fill_beat, fill_first, fill_data, fill_addr, beat_val(8, 0));
    end
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      if (fill_valid === 1'b1) beats++;
      @(negedge clk);
    end
    checks++;
    if (beats != 8) begin
      errors++;
      $display("FAIL rstmid_beats got beats=%0d exp 8", beats);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_en      = 1'b0;
    in_data    = '0;
    in_addr    = '0;
    in_size    = '0;
    in_expun   = 1'b0;
    fill_ready = 1'b0;
    inv_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_line();
    test_stall();
    test_mixed();
    test_full_overflow();
    test_push_pop_same_cycle();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
